mem_access_unit: RTL and testbench

Load/store unit sitting between the CPU's memory pipeline stage and the 4 KB word-addressed data memory. It accepts one byte/half/word load or store request at a time and converts it into word-wide memory traffic. Sub-word stores are done as read-modify-write, and sub-word loads are extracted from any byte lane with sign or zero extension. Misaligned and illegal requests get an error response and cause no memory write.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/mem_lane_align.sv | 47 ++++
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the load/store unit: access codes, FSM states and the latched request.
package mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned MEM_AW = 10;
    localparam int unsigned LD_W   = 3;
    localparam int unsigned WR_W   = 2;

    typedef enum logic [LD_W-1:0] {
        LD_NONE = 3'b000,
        LB      = 3'b001,
        LBU     = 3'b010,
        LH      = 3'b011,
        LHU     = 3'b100,
        LW      = 3'b101
    } ld_code_e;

    // Same encodings as the memory block's write port
    typedef enum logic [WR_W-1:0] {
        NO_WR = 2'b00,
        SB    = 2'b01,
        SH    = 2'b10,
        SW    = 2'b11
    } wr_code_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        DATA = 2'b10,
        WR   = 2'b11
    } state_e;

    typedef struct packed {
        logic [LD_W-1:0]   rd;
        logic [WR_W-1:0]   wr;
        logic [1:0]        off;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane extraction with extension for loads, lane merge for sub-word stores,
// and alignment checking.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_off,
    input  logic [LD_W-1:0]   i_rd,
    input  logic [WR_W-1:0]   i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_load_c,
    output logic [DATA_W-1:0] o_merge_c,
    output logic              o_misalign_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_load_c = '0;
        case (i_rd)
            LB:      o_load_c = {{24{w_byte[7]}}, w_byte};
            LBU:     o_load_c = {24'h0, w_byte};
            LH:      o_load_c = {{16{w_half[15]}}, w_half};
            LHU:     o_load_c = {16'h0, w_half};
            LW:      o_load_c = i_word;
            default: o_load_c = '0;
        endcase
    end

    always_comb begin
        o_merge_c = i_word;
        case (i_wr)
            SB:      o_merge_c[{i_off, 3'b000} +: 8]     = i_wdata[7:0];
            SH:      o_merge_c[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
            SW:      o_merge_c = i_wdata;
            default: o_merge_c = i_word;
        endcase
    end

    assign o_misalign_c = (((i_rd == LH) || (i_rd == LHU) || (i_wr == SH)) && i_off[0])
                        || (((i_rd == LW) || (i_wr == SW)) && (i_off != 2'b00));

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns byte/half/word requests into word-wide memory traffic,
// using read-modify-write for sub-word stores.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LD_W-1:0]   req_read,
    input  logic [WR_W-1:0]   req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [LD_W-1:0]   mem_read,
    output logic [WR_W-1:0]   mem_wr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_e            r_state, w_state_nxt;
    req_t              r_req, w_req_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_err, w_rsp_err_nxt;
    logic [MEM_AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [LD_W-1:0]   r_mem_read, w_mem_read_nxt;
    logic [WR_W-1:0]   r_mem_wr, w_mem_wr_nxt;
    logic [DATA_W-1:0] r_mem_din, w_mem_din_nxt;

    logic              w_idle;
    logic [1:0]        w_al_off;
    logic [LD_W-1:0]   w_al_rd;
    logic [WR_W-1:0]   w_al_wr;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merge;
    logic              w_misalign;
    logic              w_err;
    logic              w_unused_addr;

    assign w_idle        = (r_state == IDLE);
    assign w_unused_addr = ^req_addr[ADDR_W-1:12];

    // Classify the incoming request while idle; otherwise work on the latched one
    assign w_al_off = w_idle ? req_addr[1:0] : r_req.off;
    assign w_al_rd  = w_idle ? req_read      : r_req.rd;
    assign w_al_wr  = w_idle ? req_wr        : r_req.wr;

    mem_lane_align u_align (
        .i_word       (mem_dout),
        .i_off        (w_al_off),
        .i_rd         (w_al_rd),
        .i_wr         (w_al_wr),
        .i_wdata      (r_req.wdata),
        .o_load_c     (w_load),
        .o_merge_c    (w_merge),
        .o_misalign_c (w_misalign)
    );

    assign w_err = ((req_read != LD_NONE) && (req_wr != NO_WR))
                || (req_read == 3'b110) || (req_read == 3'b111)
                || w_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_read_nxt  = LD_NONE;
        w_mem_wr_nxt    = NO_WR;
        w_mem_din_nxt   = r_mem_din;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_err) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end else if ((req_read == LD_NONE) && (req_wr == NO_WR)) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b0;
                        w_rsp_rdata_nxt = '0;
                    end else if (req_wr == SW) begin
                        w_mem_addr_nxt = req_addr[11:2];
                        w_mem_din_nxt  = req_wdata;
                        w_mem_wr_nxt   = SW;
                        w_state_nxt    = WR;
                    end else begin
                        w_req_nxt      = '{rd: req_read, wr: req_wr,
                                           off: req_addr[1:0], wdata: req_wdata};
                        w_mem_addr_nxt = req_addr[11:2];
                        w_mem_read_nxt = LW;
                        w_state_nxt    = RD;
                    end
                end
            end
            RD: w_state_nxt = DATA;
            DATA: begin
                if (r_req.wr != NO_WR) begin
                    w_mem_din_nxt = w_merge;
                    w_mem_wr_nxt  = SW;
                    w_state_nxt   = WR;
                end else begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = w_load;
                    w_state_nxt     = IDLE;
                end
            end
            WR: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = 1'b0;
                w_rsp_rdata_nxt = '0;
                w_state_nxt     = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_read  <= LD_NONE;
            r_mem_wr    <= NO_WR;
            r_mem_din   <= '0;
        end else begin
            r_req       <= w_req_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_din   <= w_mem_din_nxt;
        end
    end

    assign req_ready = w_idle;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_addr  = r_mem_addr;
    assign mem_read  = r_mem_read;
    assign mem_wr    = r_mem_wr;
    assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a registered-read word memory model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_read;
    logic [1:0]  req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  mem_addr;
    logic [2:0]  mem_read;
    logic [1:0]  mem_wr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] mem [1024];
    int          n_cmp;
    int          n_fail;
    int          wr_cnt;
    int          rsp_cnt;

    mem_access_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_read  (req_read),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_wr    (mem_wr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_dout <= mem[mem_addr];
        if (mem_wr == 2'b11) mem[mem_addr] <= mem_din;
    end

    always @(negedge clk) begin
        if (mem_wr == 2'b11) wr_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from an idle negedge and wait (bounded) for its response
    task automatic do_req(input logic [2:0] rd, input logic [1:0] wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata,
                          output logic err, output int pulses);
        int w0;
        w0        = wr_cnt;
        req_valid = 1'b1;
        req_read  = rd;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = 99;
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge clk);
        pulses = wr_cnt - w0;
    endtask

    int          lat;
    int          pulses;
    int          w0;
    int          r0;
    logic [31:0] rdata;
    logic        err;

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        wr_cnt    = 0;
        rsp_cnt   = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_read  = 3'b000;
        req_wr    = 2'b00;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[16] = 32'h8765_43A1;
        repeat (3) @(negedge clk);

        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_read", 32'(mem_read), 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_din", mem_din, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(3'b001, 2'b00, 32'h0000_0040, 32'h0, lat, rdata, err, pulses);
        chk("lb_data", rdata, 32'hFFFF_FFA1);
        chk("lb_lat", 32'(lat), 32'd3);
        chk("lb_err", 32'(err), 32'd0);
        do_req(3'b010, 2'b00, 32'h0000_0041, 32'h0, lat, rdata, err, pulses);
        chk("lbu_data", rdata, 32'h0000_0043);
        chk("lbu_lat", 32'(lat), 32'd3);
        do_req(3'b011, 2'b00, 32'h0000_0042, 32'h0, lat, rdata, err, pulses);
        chk("lh_data", rdata, 32'hFFFF_8765);
        chk("lh_lat", 32'(lat), 32'd3);
        chk("lh_err", 32'(err), 32'd0);
        do_req(3'b100, 2'b00, 32'h0000_0042, 32'h0, lat, rdata, err, pulses);
        chk("lhu_data", rdata, 32'h0000_8765);
        chk("lhu_pulses", 32'(pulses), 32'd0);
        do_req(3'b010, 2'b00, 32'hFFFF_F043, 32'h0, lat, rdata, err, pulses);
        chk("lbu_wrap_data", rdata, 32'h0000_0087);

        // Held req_valid through a busy load; second request must wait for idle
        req_valid = 1'b1;
        req_read  = 3'b010;
        req_wr    = 2'b00;
        req_addr  = 32'h0000_0041;
        @(negedge clk);
        chk("held_ready_e0", 32'(req_ready), 32'd0);
        chk("held_mem_read", 32'(mem_read), 32'd5);
        chk("held_mem_addr", 32'(mem_addr), 32'h10);
        req_read  = 3'b100;
        req_addr  = 32'h0000_0042;
        @(negedge clk);
        chk("held_ready_e1", 32'(req_ready), 32'd0);
        chk("held_no_rsp_e1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("held_rsp1_valid", 32'(rsp_valid), 32'd1);
        chk("held_rsp1_data", rsp_rdata, 32'h0000_0043);
        chk("held_ready_e2", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("held_accept2", 32'(req_ready), 32'd0);
        chk("held_rsp_pulse", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("held_no_rsp_e4", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("held_rsp2_valid", 32'(rsp_valid), 32'd1);
        chk("held_rsp2_data", rsp_rdata, 32'h0000_8765);
        @(negedge clk);

        do_req(3'b000, 2'b01, 32'h0000_0042, 32'h0000_005C, lat, rdata, err, pulses);
        chk("sb_lat", 32'(lat), 32'd4);
        chk("sb_pulses", 32'(pulses), 32'd1);
        chk("sb_rdata", rdata, 32'h0);
        chk("sb_err", 32'(err), 32'd0);
        chk("sb_mem", mem[16], 32'h875C_43A1);
        do_req(3'b101, 2'b00, 32'h0000_0040, 32'h0, lat, rdata, err, pulses);
        chk("lw_after_sb", rdata, 32'h875C_43A1);

        do_req(3'b000, 2'b11, 32'h0000_0044, 32'hDEAD_BEEF, lat, rdata, err, pulses);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_pulses", 32'(pulses), 32'd1);
        chk("sw_mem", mem[17], 32'hDEAD_BEEF);
        do_req(3'b011, 2'b00, 32'h0000_0046, 32'h0, lat, rdata, err, pulses);
        chk("lh_after_sw", rdata, 32'hFFFF_DEAD);

        do_req(3'b101, 2'b00, 32'h0000_0046, 32'h0, lat, rdata, err, pulses);
        chk("lw_mis_err", 32'(err), 32'd1);
        chk("lw_mis_lat", 32'(lat), 32'd1);
        chk("lw_mis_rdata", rdata, 32'h0);
        do_req(3'b000, 2'b10, 32'h0000_0041, 32'h0000_1111, lat, rdata, err, pulses);
        chk("sh_mis_err", 32'(err), 32'd1);
        chk("sh_mis_lat", 32'(lat), 32'd1);
        chk("sh_mis_pulses", 32'(pulses), 32'd0);
        do_req(3'b111, 2'b00, 32'h0000_0040, 32'h0, lat, rdata, err, pulses);
        chk("rd111_err", 32'(err), 32'd1);
        chk("rd111_lat", 32'(lat), 32'd1);
        do_req(3'b101, 2'b11, 32'h0000_0040, 32'h1234_5678, lat, rdata, err, pulses);
        chk("rdwr_err", 32'(err), 32'd1);
        chk("rdwr_pulses", 32'(pulses), 32'd0);
        chk("err_mem16", mem[16], 32'h875C_43A1);
        chk("err_mem17", mem[17], 32'hDEAD_BEEF);
        do_req(3'b000, 2'b00, 32'h0000_0040, 32'h0, lat, rdata, err, pulses);
        chk("nop_lat", 32'(lat), 32'd1);
        chk("nop_err", 32'(err), 32'd0);
        chk("nop_rdata", rdata, 32'h0);

        // Reset while an sh sits in DATA, before its write
        w0 = wr_cnt;
        r0 = rsp_cnt;
        req_valid = 1'b1;
        req_read  = 3'b000;
        req_wr    = 2'b10;
        req_addr  = 32'h0000_0042;
        req_wdata = 32'h0000_1234;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_mem_wr_now", 32'(mem_wr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_rdata", rsp_rdata, 32'h0);
        chk("rstmid_mem_addr", 32'(mem_addr), 32'h0);
        chk("rstmid_mem_din", mem_din, 32'h0);
        chk("rstmid_mem_read", 32'(mem_read), 32'h0);
        chk("rstmid_wr_pulses", 32'(wr_cnt - w0), 32'd0);
        chk("rstmid_rsp_count", 32'(rsp_cnt - r0), 32'd0);
        chk("rstmid_mem", mem[16], 32'h875C_43A1);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(3'b101, 2'b00, 32'h0000_0040, 32'h0, lat, rdata, err, pulses);
        chk("lw_after_rst", rdata, 32'h875C_43A1);
        chk("lw_after_rst_lat", 32'(lat), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
